// File: rtl/clk_div_ctrl.sv
// Programmable clock divider. It has graceful run/stop control and a shadowed half-period
// reconfiguration that only takes effect on a phase boundary, so clk_out never has a runt phase.
module clk_div_ctrl #(
    parameter int unsigned      CNT_W        = 32,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(50_000_000)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    input  logic             err_clr,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] active_half_q, active_half_d;
    logic [CNT_W-1:0] shadow_half_q, shadow_half_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             cfg_xfer;
    logic             cfg_bad;
    logic             cfg_good;
    logic             wrap;
    logic [CNT_W-1:0] half_m1;
    logic [CNT_W-1:0] counter_inc;

    assign cfg_ready   = (state_q == StIdle) || (state_q == StRun);
    assign busy        = (state_q != StIdle);
    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign err         = err_q;

    assign cfg_xfer    = cfg_valid && cfg_ready;
    assign cfg_bad     = cfg_xfer && (cfg_half == '0);
    assign cfg_good    = cfg_xfer && (cfg_half != '0);
    assign half_m1     = active_half_q - One;
    assign counter_inc = counter_q + One;
    assign wrap        = (counter_q == half_m1);

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        active_half_d = active_half_q;
        shadow_half_d = shadow_half_q;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;
        // A zero request in the same cycle as a clear must leave err set.
        err_d         = cfg_bad | (err_q & ~err_clr);

        unique case (state_q)
            StIdle: begin
                counter_d = '0;
                clk_out_d = 1'b0;
                if (cfg_good) begin
                    active_half_d = cfg_half;
                    shadow_half_d = cfg_half;
                end
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            StRun, StPend: begin
                if (wrap) begin
                    counter_d = '0;
                    clk_out_d = ~clk_out_q;
                    tick_d    = 1'b1;
                    if (state_q == StPend) begin
                        active_half_d = shadow_half_q;
                        state_d       = StRun;
                    end
                end else begin
                    counter_d = counter_inc;
                end
                if ((state_q == StRun) && cfg_good) begin
                    shadow_half_d = cfg_half;
                    state_d       = StPend;
                end
                if (stop) begin
                    // Low phase, or the falling toggle lands on this edge: the stop is immediate.
                    if (!clk_out_q || wrap) begin
                        state_d       = StIdle;
                        counter_d     = '0;
                        clk_out_d     = 1'b0;
                        tick_d        = clk_out_q;
                        active_half_d = shadow_half_d;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (wrap) begin
                    state_d       = StIdle;
                    counter_d     = '0;
                    clk_out_d     = 1'b0;
                    tick_d        = 1'b1;
                    active_half_d = shadow_half_q;
                end else begin
                    counter_d = counter_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            counter_q     <= '0;
            active_half_q <= DEFAULT_HALF;
            shadow_half_q <= DEFAULT_HALF;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            active_half_q <= active_half_d;
            shadow_half_q <= shadow_half_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            err_q         <= err_d;
        end
    end

endmodule
